// File: rtl/sequential_accumulator_alu.sv
// Accumulator ALU with a 2*WIDTH-bit accumulator. MUL/DIV/MOD run iteratively
// (shift-add / restoring division, one bit per cycle) behind Start/Busy/Done.
module sequential_accumulator_alu #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic [3:0]         OpCode,
  input  logic [WIDTH-1:0]   InputA,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic [1:0]         Error
);
  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t           state;
  logic [3:0]       op_reg;
  logic [CW-1:0]    count;
  logic [AW-1:0]    mcand;  // MUL: left-shifting multiplicand; DIV/MOD: divisor in low half
  logic [AW-1:0]    part;   // MUL: partial product; DIV/MOD: {remainder, dividend->quotient}
  logic [WIDTH-1:0] mplr;

  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   add_res;
  logic [AW-1:0]    next_acc;
  logic [1:0]       next_err;
  logic             is_iter;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Returns {overflow, sum}; overflow is carry into MSB xor carry out of MSB.
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   s;
    logic             c_msb;
    bx    = sub ? ~b : b;
    s     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    c_msb = a[WIDTH-1] ^ bx[WIDTH-1] ^ s[WIDTH-1];
    return {s[WIDTH] ^ c_msb, s[WIDTH-1:0]};
  endfunction

  assign opnd_b    = Result[WIDTH-1:0];
  assign add_res   = add_sub(InputA, opnd_b, OpCode == 4'd5);
  assign is_iter   = (OpCode == 4'd6) ||
                     ((OpCode == 4'd7 || OpCode == 4'd8) && opnd_b != '0);
  assign div_shift = part[AW-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mcand[WIDTH-1:0]};

  always_comb begin
    next_acc = Result;
    next_err = 2'b00;
    case (OpCode)
      4'd1: next_acc = '0;
      4'd2: next_acc = '1;
      4'd4, 4'd5: begin
        next_acc = {{WIDTH{add_res[WIDTH-1]}}, add_res[WIDTH-1:0]};
        next_err = {1'b0, add_res[WIDTH]};
      end
      4'd7, 4'd8: next_err = 2'b10;  // only reached here with a zero divisor
      4'd9:  next_acc = {{WIDTH{1'b0}}, InputA & opnd_b};
      4'd10: next_acc = {{WIDTH{1'b0}}, InputA | opnd_b};
      4'd11: next_acc = {{WIDTH{1'b0}}, InputA ^ opnd_b};
      4'd12: next_acc = {{WIDTH{1'b0}}, ~(InputA & opnd_b)};
      4'd13: next_acc = {{WIDTH{1'b0}}, ~(InputA | opnd_b)};
      4'd14: next_acc = {{WIDTH{1'b0}}, ~(InputA ^ opnd_b)};
      4'd15: next_acc = {{WIDTH{1'b0}}, ~opnd_b};
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      op_reg <= '0;
      count  <= '0;
      mcand  <= '0;
      part   <= '0;
      mplr   <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
      Error  <= 2'b00;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (is_iter) begin
              state  <= ITER;
              Busy   <= 1'b1;
              count  <= CW'(WIDTH);
              op_reg <= OpCode;
              mcand  <= {{WIDTH{1'b0}}, opnd_b};
              mplr   <= InputA;
              part   <= (OpCode == 4'd6) ? '0 : {{WIDTH{1'b0}}, InputA};
            end else begin
              Result <= next_acc;
              Error  <= next_err;
              Done   <= 1'b1;
            end
          end
        end
        // ---- iteration: one multiplier or quotient bit per edge
        ITER: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIN;
            if (op_reg == 4'd6) begin
              if (mplr[0]) part <= part + mcand;
              mcand <= mcand << 1;
              mplr  <= mplr >> 1;
            end else if (div_diff[WIDTH]) begin
              part <= {div_shift[WIDTH-1:0], part[WIDTH-2:0], 1'b0};
            end else begin
              part <= {div_diff[WIDTH-1:0], part[WIDTH-2:0], 1'b1};
            end
          end
        end
        // ---- commit: Abort no longer has any effect here
        FIN: begin
          case (op_reg)
            4'd6:    Result <= part;
            4'd7:    Result <= {{WIDTH{1'b0}}, part[WIDTH-1:0]};
            default: Result <= {{WIDTH{1'b0}}, part[AW-1:WIDTH]};
          endcase
          Error <= 2'b00;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
